// File: rtl/qdrc_arb_pkg.sv
// Shared definitions for the QDR command arbiter: requester IDs,
// default widths and the round-robin pick helper.
package qdrc_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_BW_WIDTH   = 2;
  localparam int DEF_ADDR_WIDTH = 21;
  localparam int DEF_TAG_DEPTH  = 16;

  // A tie goes to the requester that was not served last; otherwise the
  // only eligible requester wins (the result is ignored when neither is).
  function automatic req_id_e rr_pick(input logic a_elig, input logic b_elig,
                                      input req_id_e last);
    if (a_elig && b_elig) begin
      return (last == REQ_A) ? REQ_B : REQ_A;
    end else if (b_elig) begin
      return REQ_B;
    end
    return REQ_A;
  endfunction

endpackage

// File: rtl/qdrc_tag_fifo.sv
// Outstanding-read tag FIFO: one bit per entry recording which requester
// owns each issued read. Supports push and pop in the same cycle at any
// fill level; a pop on an empty FIFO is ignored.
module qdrc_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Flags, read port and pointer/memory next state; a pop at full frees the slot a same-cycle push needs.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // State registers, cleared to empty on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/qdrc_arb.sv
// Two-requester QDR command arbiter. Each requester has a one-entry hold
// register; a round-robin grant moves one entry per cycle to the registered
// PHY command outputs, and read returns are routed back by tag.
module qdrc_arb
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BW_WIDTH   = DEF_BW_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_wr_strb,
  input  logic                    a_rd_strb,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [2*DATA_WIDTH-1:0] a_wr_data,
  input  logic [2*BW_WIDTH-1:0]   a_wr_ben,
  output logic                    a_rdy,
  output logic [2*DATA_WIDTH-1:0] a_rd_data,
  output logic                    a_rd_dvld,
  input  logic                    b_wr_strb,
  input  logic                    b_rd_strb,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [2*DATA_WIDTH-1:0] b_wr_data,
  input  logic [2*BW_WIDTH-1:0]   b_wr_ben,
  output logic                    b_rdy,
  output logic [2*DATA_WIDTH-1:0] b_rd_data,
  output logic                    b_rd_dvld,
  output logic                    phy_wr_strb,
  output logic                    phy_rd_strb,
  output logic [ADDR_WIDTH-1:0]   phy_addr,
  output logic [2*DATA_WIDTH-1:0] phy_wr_data,
  output logic [2*BW_WIDTH-1:0]   phy_wr_ben,
  input  logic [2*DATA_WIDTH-1:0] phy_rd_data,
  input  logic                    phy_rd_dvld,
  output logic                    tag_err
);

  localparam int DW = 2 * DATA_WIDTH;
  localparam int BW = 2 * BW_WIDTH;

  // Requester inputs gathered into arrays indexed by requester ID.
  logic [1:0]                 cmd_wr, cmd_rd;
  logic [1:0][ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0][DW-1:0]         cmd_data;
  logic [1:0][BW-1:0]         cmd_ben;

  assign cmd_wr   = {b_wr_strb, a_wr_strb};
  assign cmd_rd   = {b_rd_strb, a_rd_strb};
  assign cmd_addr = {b_addr, a_addr};
  assign cmd_data = {b_wr_data, a_wr_data};
  assign cmd_ben  = {b_wr_ben, a_wr_ben};

  logic [1:0]                 hold_vld_q, hold_vld_d;
  logic [1:0]                 hold_wr_q, hold_wr_d;
  logic [1:0]                 hold_rd_q, hold_rd_d;
  logic [1:0][ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [1:0][DW-1:0]         hold_data_q, hold_data_d;
  logic [1:0][BW-1:0]         hold_ben_q, hold_ben_d;
  req_id_e                    last_q, last_d;

  logic                  phy_wr_q, phy_wr_d, phy_rd_q, phy_rd_d;
  logic [ADDR_WIDTH-1:0] phy_addr_q, phy_addr_d;
  logic [DW-1:0]         phy_data_q, phy_data_d;
  logic [BW-1:0]         phy_ben_q, phy_ben_d;

  logic [1:0]         rd_dvld_q, rd_dvld_d;
  logic [1:0][DW-1:0] rd_data_q, rd_data_d;
  logic               tag_err_q, tag_err_d;

  logic [1:0] elig, rdy;
  logic       grant_vld, grant_sel, ret_ok;
  req_id_e    grant_id;
  logic       fifo_push, fifo_tag, fifo_full, fifo_empty;

  // Arbitration: a read-carrying entry waits while the tag FIFO is full; the tag is pushed on the grant edge.
  always_comb begin
    elig[0]   = hold_vld_q[0] && !(hold_rd_q[0] && fifo_full);
    elig[1]   = hold_vld_q[1] && !(hold_rd_q[1] && fifo_full);
    grant_vld = |elig;
    grant_id  = rr_pick(elig[0], elig[1], last_q);
    grant_sel = grant_id;
    rdy[0]    = !hold_vld_q[0] || (grant_vld && (grant_sel == 1'b0));
    rdy[1]    = !hold_vld_q[1] || (grant_vld && (grant_sel == 1'b1));
    fifo_push = grant_vld && hold_rd_q[grant_sel];
    last_d    = grant_vld ? grant_id : last_q;
  end

  // Hold registers load an accepted command, otherwise empty once granted.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_wr_d   = hold_wr_q;
    hold_rd_d   = hold_rd_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_ben_d  = hold_ben_q;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] && (cmd_wr[i] || cmd_rd[i])) begin
        hold_vld_d[i]  = 1'b1;
        hold_wr_d[i]   = cmd_wr[i];
        hold_rd_d[i]   = cmd_rd[i];
        hold_addr_d[i] = cmd_addr[i];
        hold_data_d[i] = cmd_data[i];
        hold_ben_d[i]  = cmd_ben[i];
      end else if (grant_vld && (grant_sel == i[0])) begin
        hold_vld_d[i] = 1'b0;
      end
    end
  end

  // Granted entry is copied to the PHY outputs; strobes drop when nothing is granted.
  always_comb begin
    phy_wr_d   = grant_vld && hold_wr_q[grant_sel];
    phy_rd_d   = grant_vld && hold_rd_q[grant_sel];
    phy_addr_d = grant_vld ? hold_addr_q[grant_sel] : phy_addr_q;
    phy_data_d = grant_vld ? hold_data_q[grant_sel] : phy_data_q;
    phy_ben_d  = grant_vld ? hold_ben_q[grant_sel] : phy_ben_q;
  end

  // Read returns are steered by the oldest tag; a return with no tag is dropped and flagged.
  always_comb begin
    ret_ok       = phy_rd_dvld && !fifo_empty;
    rd_dvld_d[0] = ret_ok && !fifo_tag;
    rd_dvld_d[1] = ret_ok && fifo_tag;
    rd_data_d    = rd_data_q;
    if (rd_dvld_d[0]) rd_data_d[0] = phy_rd_data;
    if (rd_dvld_d[1]) rd_data_d[1] = phy_rd_data;
    tag_err_d    = tag_err_q || (phy_rd_dvld && fifo_empty);
  end

  // All state clears on reset; the pointer starts at B so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_vld_q  <= '0;
      hold_wr_q   <= '0;
      hold_rd_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_ben_q  <= '0;
      last_q      <= REQ_B;
      phy_wr_q    <= 1'b0;
      phy_rd_q    <= 1'b0;
      phy_addr_q  <= '0;
      phy_data_q  <= '0;
      phy_ben_q   <= '0;
      rd_dvld_q   <= '0;
      rd_data_q   <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_wr_q   <= hold_wr_d;
      hold_rd_q   <= hold_rd_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_ben_q  <= hold_ben_d;
      last_q      <= last_d;
      phy_wr_q    <= phy_wr_d;
      phy_rd_q    <= phy_rd_d;
      phy_addr_q  <= phy_addr_d;
      phy_data_q  <= phy_data_d;
      phy_ben_q   <= phy_ben_d;
      rd_dvld_q   <= rd_dvld_d;
      rd_data_q   <= rd_data_d;
      tag_err_q   <= tag_err_d;
    end
  end

  qdrc_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(grant_sel),
    .pop      (phy_rd_dvld),
    .pop_data (fifo_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign a_rdy       = rdy[0];
  assign b_rdy       = rdy[1];
  assign a_rd_dvld   = rd_dvld_q[0];
  assign b_rd_dvld   = rd_dvld_q[1];
  assign a_rd_data   = rd_data_q[0];
  assign b_rd_data   = rd_data_q[1];
  assign phy_wr_strb = phy_wr_q;
  assign phy_rd_strb = phy_rd_q;
  assign phy_addr    = phy_addr_q;
  assign phy_wr_data = phy_data_q;
  assign phy_wr_ben  = phy_ben_q;
  assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_qdrc_arb.sv
// Bench for qdrc_arb: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a queue-based
// behavioural model of the arbiter.
module tb_qdrc_arb;

  localparam int DATA_WIDTH = 18;
  localparam int BW_WIDTH   = 2;
  localparam int ADDR_WIDTH = 21;
  localparam int TAG_DEPTH  = 16;
  localparam int DW         = 2 * DATA_WIDTH;
  localparam int BEW        = 2 * BW_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  a_wr_strb = 1'b0, a_rd_strb = 1'b0;
  logic [ADDR_WIDTH-1:0] a_addr = '0;
  logic [DW-1:0]         a_wr_data = '0;
  logic [BEW-1:0]        a_wr_ben = '0;
  logic                  a_rdy, a_rd_dvld;
  logic [DW-1:0]         a_rd_data;
  logic                  b_wr_strb = 1'b0, b_rd_strb = 1'b0;
  logic [ADDR_WIDTH-1:0] b_addr = '0;
  logic [DW-1:0]         b_wr_data = '0;
  logic [BEW-1:0]        b_wr_ben = '0;
  logic                  b_rdy, b_rd_dvld;
  logic [DW-1:0]         b_rd_data;
  logic                  phy_wr_strb, phy_rd_strb;
  logic [ADDR_WIDTH-1:0] phy_addr;
  logic [DW-1:0]         phy_wr_data;
  logic [BEW-1:0]        phy_wr_ben;
  logic [DW-1:0]         phy_rd_data = '0;
  logic                  phy_rd_dvld = 1'b0;
  logic                  tag_err;

  qdrc_arb #(
    .DATA_WIDTH(DATA_WIDTH),
    .BW_WIDTH  (BW_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_wr_strb  (a_wr_strb),
    .a_rd_strb  (a_rd_strb),
    .a_addr     (a_addr),
    .a_wr_data  (a_wr_data),
    .a_wr_ben   (a_wr_ben),
    .a_rdy      (a_rdy),
    .a_rd_data  (a_rd_data),
    .a_rd_dvld  (a_rd_dvld),
    .b_wr_strb  (b_wr_strb),
    .b_rd_strb  (b_rd_strb),
    .b_addr     (b_addr),
    .b_wr_data  (b_wr_data),
    .b_wr_ben   (b_wr_ben),
    .b_rdy      (b_rdy),
    .b_rd_data  (b_rd_data),
    .b_rd_dvld  (b_rd_dvld),
    .phy_wr_strb(phy_wr_strb),
    .phy_rd_strb(phy_rd_strb),
    .phy_addr   (phy_addr),
    .phy_wr_data(phy_wr_data),
    .phy_wr_ben (phy_wr_ben),
    .phy_rd_data(phy_rd_data),
    .phy_rd_dvld(phy_rd_dvld),
    .tag_err    (tag_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: pending command per requester, last served
  // requester, queue of outstanding read owners, and expected outputs.
  bit                    m_pend[2], m_pwr[2], m_prd[2];
  logic [ADDR_WIDTH-1:0] m_paddr[2];
  logic [DW-1:0]         m_pdata[2];
  logic [BEW-1:0]        m_pben[2];
  int                    m_last;
  int                    m_tags[$];
  bit                    e_wr, e_rd, e_err;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [DW-1:0]         e_data;
  logic [BEW-1:0]        e_ben;
  bit                    e_dvld[2];
  logic [DW-1:0]         e_rdata[2];

  bit                    in_wr[2], in_rd[2];
  logic [ADDR_WIDTH-1:0] in_addr[2];
  logic [DW-1:0]         in_data[2];
  logic [BEW-1:0]        in_ben[2];
  bit                    m_full, m_gv;
  bit                    m_elig[2], m_rdy[2];
  int                    m_g, m_t;

  // Model returns to its power-on picture: nothing pending, B served last.
  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i]  = 1'b0;
      e_dvld[i]  = 1'b0;
      e_rdata[i] = '0;
    end
    m_last = 1;
    m_tags.delete();
    e_wr   = 1'b0;
    e_rd   = 1'b0;
    e_err  = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_ben  = '0;
  endfunction

  // Compare process: at every falling edge outside reset, derive this
  // cycle's rdy from the model, compare every DUT output, then advance
  // the model by one cycle using the inputs the DUT will sample next.
  always @(negedge clk) begin
    if (reset) begin
      modelReset();
    end else begin
      in_wr[0] = a_wr_strb;   in_wr[1] = b_wr_strb;
      in_rd[0] = a_rd_strb;   in_rd[1] = b_rd_strb;
      in_addr[0] = a_addr;    in_addr[1] = b_addr;
      in_data[0] = a_wr_data; in_data[1] = b_wr_data;
      in_ben[0] = a_wr_ben;   in_ben[1] = b_wr_ben;

      m_full = (m_tags.size() >= TAG_DEPTH);
      for (int i = 0; i < 2; i++) m_elig[i] = m_pend[i] && !(m_prd[i] && m_full);
      m_gv = m_elig[0] || m_elig[1];
      if (m_elig[0] && m_elig[1]) m_g = 1 - m_last;
      else if (m_elig[1])         m_g = 1;
      else                        m_g = 0;
      for (int i = 0; i < 2; i++) m_rdy[i] = !m_pend[i] || (m_gv && m_g == i);

      checkOutput("mdl_a_rdy", a_rdy, m_rdy[0]);
      checkOutput("mdl_b_rdy", b_rdy, m_rdy[1]);
      checkOutput("mdl_phy_wr_strb", phy_wr_strb, e_wr);
      checkOutput("mdl_phy_rd_strb", phy_rd_strb, e_rd);
      if (e_wr || e_rd) begin
        checkOutput("mdl_phy_addr", phy_addr, e_addr);
        checkOutput("mdl_phy_wr_data", phy_wr_data, e_data);
        checkOutput("mdl_phy_wr_ben", phy_wr_ben, e_ben);
      end
      checkOutput("mdl_a_rd_dvld", a_rd_dvld, e_dvld[0]);
      checkOutput("mdl_b_rd_dvld", b_rd_dvld, e_dvld[1]);
      checkOutput("mdl_a_rd_data", a_rd_data, e_rdata[0]);
      checkOutput("mdl_b_rd_data", b_rd_data, e_rdata[1]);
      checkOutput("mdl_tag_err", tag_err, e_err);

      e_dvld[0] = 1'b0;
      e_dvld[1] = 1'b0;
      if (phy_rd_dvld) begin
        if (m_tags.size() > 0) begin
          m_t = m_tags.pop_front();
          e_dvld[m_t]  = 1'b1;
          e_rdata[m_t] = phy_rd_data;
        end else begin
          e_err = 1'b1;
        end
      end
      if (m_gv) begin
        e_wr   = m_pwr[m_g];
        e_rd   = m_prd[m_g];
        e_addr = m_paddr[m_g];
        e_data = m_pdata[m_g];
        e_ben  = m_pben[m_g];
        if (m_prd[m_g]) m_tags.push_back(m_g);
        m_last = m_g;
      end else begin
        e_wr = 1'b0;
        e_rd = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_rdy[i] && (in_wr[i] || in_rd[i])) begin
          m_pend[i]  = 1'b1;
          m_pwr[i]   = in_wr[i];
          m_prd[i]   = in_rd[i];
          m_paddr[i] = in_addr[i];
          m_pdata[i] = in_data[i];
          m_pben[i]  = in_ben[i];
        end else if (m_gv && m_g == i) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's worth of requester commands and PHY return.
  task automatic applyStimulus(
      input bit awr, input bit ard, input logic [ADDR_WIDTH-1:0] aad,
      input logic [DW-1:0] adat, input logic [BEW-1:0] aben,
      input bit bwr, input bit brd, input logic [ADDR_WIDTH-1:0] bad,
      input logic [DW-1:0] bdat, input logic [BEW-1:0] bben,
      input bit rdv, input logic [DW-1:0] rdat);
    a_wr_strb = awr; a_rd_strb = ard; a_addr = aad; a_wr_data = adat; a_wr_ben = aben;
    b_wr_strb = bwr; b_rd_strb = brd; b_addr = bad; b_wr_data = bdat; b_wr_ben = bben;
    phy_rd_dvld = rdv; phy_rd_data = rdat;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0, '0);
  endtask

  // Two-cycle reset pulse; returns just after a rising edge with reset low.
  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected phy address order and rdy patterns while both requesters stream writes.
  int exp_addr[9] = '{'h100, 'h200, 'h101, 'h202, 'h103, 'h204, 'h105, 'h206, 'h107};
  bit exp_ardy[8] = '{1, 1, 0, 1, 0, 1, 0, 1};
  bit exp_brdy[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [63:0] rnd;
    int          ret_pct, aop, bop;
    bit          rdv;

    $display("[TB] start");

    // Single write from A reaches the PHY two cycles later.
    doReset();
    checkOutput("rst_a_rdy", a_rdy, 1);
    checkOutput("rst_b_rdy", b_rdy, 1);
    checkOutput("rst_phy_wr", phy_wr_strb, 0);
    checkOutput("rst_tag_err", tag_err, 0);
    checkOutput("rst_phy_addr", phy_addr, 0);
    applyStimulus(1, 0, 'h10, 'h123456789, 'hF, 0, 0, '0, '0, '0, 0, '0);
    tick(); idleInputs();
    checkOutput("wr1_c1_strb", phy_wr_strb, 0);
    tick();
    checkOutput("wr1_c2_strb", phy_wr_strb, 1);
    checkOutput("wr1_c2_rd", phy_rd_strb, 0);
    checkOutput("wr1_c2_addr", phy_addr, 'h10);
    checkOutput("wr1_c2_data", phy_wr_data, 'h123456789);
    checkOutput("wr1_c2_ben", phy_wr_ben, 'hF);
    tick();
    checkOutput("wr1_c3_strb", phy_wr_strb, 0);

    // Simultaneous reads: A first, B next; returns routed in order.
    doReset();
    applyStimulus(0, 1, 'h20, '0, '0, 0, 1, 'h30, '0, '0, 0, '0);
    tick(); idleInputs();
    checkOutput("rd2_c1_strb", phy_rd_strb, 0);
    tick();
    checkOutput("rd2_c2_strb", phy_rd_strb, 1);
    checkOutput("rd2_c2_addr", phy_addr, 'h20);
    tick();
    checkOutput("rd2_c3_strb", phy_rd_strb, 1);
    checkOutput("rd2_c3_addr", phy_addr, 'h30);
    tick();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 'hAAAA1111);
    tick();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 'hBBBB2222);
    checkOutput("rd2_c5_a_dvld", a_rd_dvld, 1);
    checkOutput("rd2_c5_a_data", a_rd_data, 'hAAAA1111);
    checkOutput("rd2_c5_b_dvld", b_rd_dvld, 0);
    tick(); idleInputs();
    checkOutput("rd2_c6_b_dvld", b_rd_dvld, 1);
    checkOutput("rd2_c6_b_data", b_rd_data, 'hBBBB2222);
    checkOutput("rd2_c6_a_dvld", a_rd_dvld, 0);
    checkOutput("rd2_c6_a_hold", a_rd_data, 'hAAAA1111);

    // Both requesters stream writes: grants alternate A,B,A,...
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, 0, ADDR_WIDTH'('h100 + c), DW'('hA00 + c), 'h3,
                    1, 0, ADDR_WIDTH'('h200 + c), DW'('hB00 + c), 'hC, 0, '0);
      checkOutput("rr_a_rdy", a_rdy, exp_ardy[c]);
      checkOutput("rr_b_rdy", b_rdy, exp_brdy[c]);
      if (c >= 2) begin
        checkOutput("rr_strb", phy_wr_strb, 1);
        checkOutput("rr_addr", phy_addr, exp_addr[c-2]);
      end
      tick();
    end
    idleInputs();
    for (int c = 8; c < 11; c++) begin
      checkOutput("rr_tail_strb", phy_wr_strb, 1);
      checkOutput("rr_tail_addr", phy_addr, exp_addr[c-2]);
      tick();
    end
    checkOutput("rr_done_strb", phy_wr_strb, 0);

    // Tag FIFO fills: the 17th read waits, a B write bypasses it, a return unblocks A.
    doReset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, 1, ADDR_WIDTH'('h300 + k), '0, '0, 0, 0, '0, '0, '0, 0, '0);
      checkOutput("full_a_rdy", a_rdy, 1);
      tick();
    end
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 'h555, 'h5A5A, 'hF, 0, '0);
    checkOutput("full_c17_a_rdy", a_rdy, 0);
    checkOutput("full_c17_b_rdy", b_rdy, 1);
    checkOutput("full_c17_rd", phy_rd_strb, 1);
    checkOutput("full_c17_addr", phy_addr, 'h30F);
    tick(); idleInputs();
    checkOutput("full_c18_a_rdy", a_rdy, 0);
    checkOutput("full_c18_rd", phy_rd_strb, 0);
    tick();
    checkOutput("full_c19_wr", phy_wr_strb, 1);
    checkOutput("full_c19_addr", phy_addr, 'h555);
    checkOutput("full_c19_rd", phy_rd_strb, 0);
    tick();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 'h777);
    checkOutput("full_c20_a_rdy", a_rdy, 0);
    tick(); idleInputs();
    checkOutput("full_c21_a_rdy", a_rdy, 1);
    checkOutput("full_c21_dvld", a_rd_dvld, 1);
    checkOutput("full_c21_data", a_rd_data, 'h777);
    tick();
    checkOutput("full_c22_rd", phy_rd_strb, 1);
    checkOutput("full_c22_addr", phy_addr, 'h310);

    // Return with nothing outstanding: dropped, sticky error until reset.
    doReset();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 'h999);
    tick(); idleInputs();
    checkOutput("err_a_dvld", a_rd_dvld, 0);
    checkOutput("err_b_dvld", b_rd_dvld, 0);
    checkOutput("err_a_data", a_rd_data, 0);
    checkOutput("err_flag", tag_err, 1);
    tick(); tick();
    checkOutput("err_sticky", tag_err, 1);
    doReset();
    checkOutput("err_cleared", tag_err, 0);

    // Reset mid-burst with three reads outstanding; late returns are discarded.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, ADDR_WIDTH'('h400 + k), '0, '0, 0, 0, '0, '0, '0, 0, '0);
      tick();
    end
    idleInputs();
    tick();
    checkOutput("mid_c4_rd", phy_rd_strb, 1);
    checkOutput("mid_c4_addr", phy_addr, 'h402);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rd", phy_rd_strb, 0);
    checkOutput("mid_rst_addr", phy_addr, 0);
    checkOutput("mid_rst_err", tag_err, 0);
    checkOutput("mid_rst_dvld", a_rd_dvld, 0);
    tick(); tick();
    reset = 1'b0;
    checkOutput("mid_post_a_rdy", a_rdy, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, DW'('h800 + k));
      tick();
      checkOutput("mid_late_dvld", a_rd_dvld, 0);
      checkOutput("mid_late_err", tag_err, 1);
    end

    // Randomized traffic; return rate alternates to exercise both full and drained FIFO.
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) doReset();
      ret_pct = ((cyc / 400) % 2 == 1) ? 70 : 8;
      aop = $urandom_range(0, 3);
      bop = $urandom_range(0, 3);
      rdv = (m_tags.size() > 0) && ($urandom_range(0, 99) < ret_pct);
      rnd = {$urandom(), $urandom()};
      applyStimulus(aop[0], aop[1], ADDR_WIDTH'($urandom()), rnd[DW-1:0], BEW'($urandom()),
                    bop[0], bop[1], ADDR_WIDTH'($urandom()), DW'({$urandom(), $urandom()}),
                    BEW'($urandom()), rdv, DW'({$urandom(), $urandom()}));
      tick();
    end
    idleInputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
